ctrl_regs_block: RTL and testbench
==================================

# ctrl_regs_block

Control/status register file in the command-driven configuration path. An initiator issues one idle, read or write command per clock on a flat command bus. The block holds three control registers, a scratch register, access-statistics counters and a fixed ID word. Control register outputs are internal only; other blocks take them by hierarchy or a later port extension.

## Interface
Parameters:
- `ID_VALUE`, default 32'hC7A1_0001: constant returned at address 0x1C.

Ports (reset is rstn, asynchronous, active-high; clock is clk):
- `clk`  in  1  clock; all state changes on its rising edge.
- `rstn`  in  1  reset, asynchronous, active-high; all state clears while rstn=1.
- `cmd_i`  in  2  command: 2'b00 IDLE, 2'b01 RD, 2'b10 WR, 2'b11 illegal.
- `cmd_addr_i`  in  8  byte address, sampled with cmd_i.
- `cmd_data_i`  in  32  write data, sampled when cmd_i=WR.
- `cmd_data_o`  out  32  read data, registered.

## Operation
Register map (the full 8-bit address must match; any other address is unmapped):
- 0x00 CTRL0, 0x04 CTRL1, 0x08 CTRL2:
  - RW.
  - Bits [5:0] are writable: [0] en, [2:1] prio, [5:3] pkt_len.
  - Bits [31:6] are reserved, read 0, and ignore writes.
  - Reset value 0.
- 0x0C SCRATCH: RW, all 32 bits, reset 0.
- 0x10 STAT_WR: RO.
  - [15:0] count of accepted writes to RW registers.
  - Saturates at 0xFFFF. [31:16] read 0.
- 0x14 STAT_RD: RO.
  - [15:0] count of RD commands to mapped addresses.
  - Saturates at 0xFFFF. [31:16] read 0.
- 0x18 STAT_ERR: RO.
  - [15:0] error count, saturating at 0xFFFF.
  - Increments on any of: cmd=2'b11, WR to an RO address, RD or WR to an unmapped address.
- 0x1C ID: RO, returns ID_VALUE.

Commands:
- WR to an RW address: the register takes cmd_data_i masked by its writable bits; STAT_WR increments.
- WR to an RO or unmapped address: no register changes; STAT_ERR increments.
- RD: cmd_data_o loads the addressed register value.
  - An unmapped read loads 0 and increments STAT_ERR.
  - A mapped read increments STAT_RD.
  - A read of a STAT register returns its value before any increment made in the same cycle.
- IDLE: no state change; cmd_data_o holds its last value.
- 2'b11: treated as IDLE except that STAT_ERR increments.
- Each cycle carries at most one command, so no simultaneous accesses are possible.

## Timing
- Writes take effect at the rising edge on which cmd_i=WR. A RD in the next cycle returns the new value.
- Read latency is 1 cycle:
  - RD presented in cycle N produces cmd_data_o valid after the edge ending cycle N.
  - The value holds until the next RD or reset.
- There is no handshake; every command is accepted in a single cycle.
- Reset values, all applied asynchronously:
  - cmd_data_o = 0.
  - CTRL0, CTRL1, CTRL2, SCRATCH = 0.
  - All counters = 0.
- Reset asserted mid-sequence clears everything immediately. Commands presented while rstn=1 are ignored.
- The first command is accepted on the first rising edge after rstn falls.

## Test plan
- Reset: hold rstn=1 for 3 cycles, then release → cmd_data_o=0. Subsequent reads of 0x00–0x18 all return 0; a read of 0x1C returns 0xC7A1_0001.
- Masked write: WR 0x00 with 0xFFFF_FFFF, then RD 0x00 → cmd_data_o=0x0000_003F one cycle after the RD. Then IDLE for 5 cycles → cmd_data_o stays 0x0000_003F.
- Scratch and back-to-back: WR 0x0C with 0xA5A5_5A5A, followed immediately by RD 0x0C → 0xA5A5_5A5A. Then RD 0x10 → 0x0000_0001; RD 0x14 → 0x0000_0002.
- Errors: in order, cmd=2'b11; WR 0x1C with 0x1234; RD 0x03; RD 0x18.
  - RD 0x03 returns 0.
  - RD 0x18 returns 0x0000_0003.
  - A following RD 0x1C still returns 0xC7A1_0001.
- Reset mid-operation: WR 0x04 with 0x15, assert rstn for 1 cycle, then RD 0x04 → 0. cmd_data_o reads 0 while reset is asserted.
- Saturation: issue 65540 WRs to 0x08, then RD 0x10 → 0x0000_FFFF.

Source files
------------

// File: rtl/ctrl_regs_block.sv
// Control/status register file driven by a flat one-command-per-cycle bus.
// Holds three masked control registers, a scratch word, saturating access counters and an ID.
module ctrl_regs_block #(
   parameter logic [31:0] ID_VALUE = 32'hC7A1_0001
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [1:0]  cmd_i,
   input  logic [7:0]  cmd_addr_i,
   input  logic [31:0] cmd_data_i,
   output logic [31:0] cmd_data_o
);

   typedef enum logic [1:0] {CmdIdle = 2'b00, CmdRd = 2'b01, CmdWr = 2'b10, CmdIll = 2'b11} cmd_e;

   localparam logic [7:0] AddrCtrl0   = 8'h00;
   localparam logic [7:0] AddrCtrl1   = 8'h04;
   localparam logic [7:0] AddrCtrl2   = 8'h08;
   localparam logic [7:0] AddrScratch = 8'h0C;
   localparam logic [7:0] AddrStatWr  = 8'h10;
   localparam logic [7:0] AddrStatRd  = 8'h14;
   localparam logic [7:0] AddrStatErr = 8'h18;
   localparam logic [7:0] AddrId      = 8'h1C;

   logic [5:0]  ctrl0_q, ctrl0_d;
   logic [5:0]  ctrl1_q, ctrl1_d;
   logic [5:0]  ctrl2_q, ctrl2_d;
   logic [31:0] scratch_q, scratch_d;
   logic [15:0] stat_wr_q, stat_wr_d;
   logic [15:0] stat_rd_q, stat_rd_d;
   logic [15:0] stat_err_q, stat_err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        is_rd, is_wr, is_ill;
   logic        rw_hit, mapped;
   logic [31:0] rd_val;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Address decode and read mux; unmapped addresses read as zero
   always_comb begin
      rw_hit = 1'b0;
      mapped = 1'b1;
      rd_val = '0;
      case (cmd_addr_i)
         AddrCtrl0: begin
            rw_hit = 1'b1;
            rd_val = {26'd0, ctrl0_q};
         end
         AddrCtrl1: begin
            rw_hit = 1'b1;
            rd_val = {26'd0, ctrl1_q};
         end
         AddrCtrl2: begin
            rw_hit = 1'b1;
            rd_val = {26'd0, ctrl2_q};
         end
         AddrScratch: begin
            rw_hit = 1'b1;
            rd_val = scratch_q;
         end
         AddrStatWr:  rd_val = {16'd0, stat_wr_q};
         AddrStatRd:  rd_val = {16'd0, stat_rd_q};
         AddrStatErr: rd_val = {16'd0, stat_err_q};
         AddrId:      rd_val = ID_VALUE;
         default:     mapped = 1'b0;
      endcase
   end

   always_comb begin
      is_rd  = (cmd_e'(cmd_i) == CmdRd);
      is_wr  = (cmd_e'(cmd_i) == CmdWr);
      is_ill = (cmd_e'(cmd_i) == CmdIll);

      ctrl0_d    = ctrl0_q;
      ctrl1_d    = ctrl1_q;
      ctrl2_d    = ctrl2_q;
      scratch_d  = scratch_q;
      stat_wr_d  = stat_wr_q;
      stat_rd_d  = stat_rd_q;
      stat_err_d = stat_err_q;
      rdata_d    = rdata_q;

      if (is_wr && rw_hit) begin
         stat_wr_d = sat_inc(stat_wr_q);
         case (cmd_addr_i)
            AddrCtrl0:   ctrl0_d   = cmd_data_i[5:0];
            AddrCtrl1:   ctrl1_d   = cmd_data_i[5:0];
            AddrCtrl2:   ctrl2_d   = cmd_data_i[5:0];
            AddrScratch: scratch_d = cmd_data_i;
            default: ;
         endcase
      end

      if (is_rd) begin
         // rd_val is taken from the current state, so a STAT read sees its pre-increment value
         rdata_d = rd_val;
         if (mapped) stat_rd_d = sat_inc(stat_rd_q);
      end

      if (is_ill || (is_wr && !rw_hit) || (is_rd && !mapped)) begin
         stat_err_d = sat_inc(stat_err_q);
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         ctrl0_q    <= '0;
         ctrl1_q    <= '0;
         ctrl2_q    <= '0;
         scratch_q  <= '0;
         stat_wr_q  <= '0;
         stat_rd_q  <= '0;
         stat_err_q <= '0;
         rdata_q    <= '0;
      end else begin
         ctrl0_q    <= ctrl0_d;
         ctrl1_q    <= ctrl1_d;
         ctrl2_q    <= ctrl2_d;
         scratch_q  <= scratch_d;
         stat_wr_q  <= stat_wr_d;
         stat_rd_q  <= stat_rd_d;
         stat_err_q <= stat_err_d;
         rdata_q    <= rdata_d;
      end
   end

   assign cmd_data_o = rdata_q;

endmodule

// File: tb/tb_ctrl_regs_block.sv
// Self-checking bench for ctrl_regs_block: directed scenarios followed by random commands,
// all compared against a behavioural register-map model.
module tb_ctrl_regs_block;

   localparam logic [31:0] IdValue = 32'hC7A1_0001;
   localparam logic [1:0]  Idle = 2'b00, Rd = 2'b01, Wr = 2'b10, Ill = 2'b11;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [1:0]  cmd_i = 2'b00;
   logic [7:0]  cmd_addr_i = 8'h00;
   logic [31:0] cmd_data_i = 32'h0;
   logic [31:0] cmd_data_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_ctrl [3];
   logic [31:0] m_scratch;
   int          m_wr, m_rd, m_err;
   logic [31:0] m_rdata;

   ctrl_regs_block #(.ID_VALUE(IdValue)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .cmd_i      (cmd_i),
      .cmd_addr_i (cmd_addr_i),
      .cmd_data_i (cmd_data_i),
      .cmd_data_o (cmd_data_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_ctrl[i] = '0;
      m_scratch = '0;
      m_wr = 0;
      m_rd = 0;
      m_err = 0;
      m_rdata = '0;
   endtask

   // Read value of an address in the model; hit=0 for unmapped addresses
   task automatic model_read(input logic [7:0] a, output logic [31:0] v, output bit hit);
      hit = 1'b1;
      case (a)
         8'h00, 8'h04, 8'h08: v = m_ctrl[a >> 2];
         8'h0C: v = m_scratch;
         8'h10: v = 32'(m_wr);
         8'h14: v = 32'(m_rd);
         8'h18: v = 32'(m_err);
         8'h1C: v = IdValue;
         default: begin
            v = '0;
            hit = 1'b0;
         end
      endcase
   endtask

   task automatic model_cmd(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d);
      logic [31:0] v;
      bit          hit;
      model_read(a, v, hit);
      case (c)
         Rd: begin
            m_rdata = v;
            if (hit) m_rd = sat(m_rd + 1);
            else m_err = sat(m_err + 1);
         end
         Wr: begin
            if (a == 8'h00 || a == 8'h04 || a == 8'h08) begin
               m_ctrl[a >> 2] = d & 32'h3F;
               m_wr = sat(m_wr + 1);
            end else if (a == 8'h0C) begin
               m_scratch = d;
               m_wr = sat(m_wr + 1);
            end else begin
               m_err = sat(m_err + 1);
            end
         end
         Ill: m_err = sat(m_err + 1);
         default: ;
      endcase
   endtask

   // One command for one clock; output compared to the model after the edge unless tag is empty
   task automatic step(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d,
                       input string tag);
      cmd_i = c;
      cmd_addr_i = a;
      cmd_data_i = d;
      @(posedge clk);
      #1;
      model_cmd(c, a, d);
      cmd_i = Idle;
      if (tag != "") check(tag, cmd_data_o, m_rdata);
   endtask

   task automatic do_reset(input int n);
      cmd_i = Idle;
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("rst_async", cmd_data_o, 32'h0);
      repeat (n) @(posedge clk);
      #1;
      check("rst_hold", cmd_data_o, 32'h0);
      rstn = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [7:0] a;
      logic [1:0] c;
      model_reset();
      #2;

      // Reset state: each address read on its own after reset
      do_reset(3);
      check("reset_out", cmd_data_o, 32'h0);
      for (int i = 0; i < 7; i++) begin
         do_reset(1);
         step(Rd, 8'(i * 4), 32'h0, "reset_read");
         check("reset_read_zero", cmd_data_o, 32'h0);
      end
      step(Rd, 8'h1C, 32'h0, "reset_id");
      check("reset_id_const", cmd_data_o, 32'hC7A1_0001);

      // Masked write then hold across idles
      do_reset(1);
      step(Wr, 8'h00, 32'hFFFF_FFFF, "mask_wr");
      step(Rd, 8'h00, 32'h0, "mask_rd");
      check("mask_rd_const", cmd_data_o, 32'h0000_003F);
      for (int i = 0; i < 5; i++) step(Idle, 8'h00, 32'hDEAD_BEEF, "mask_idle");
      check("mask_hold_const", cmd_data_o, 32'h0000_003F);

      // Scratch with back-to-back read, then statistics
      do_reset(1);
      step(Wr, 8'h0C, 32'hA5A5_5A5A, "scr_wr");
      step(Rd, 8'h0C, 32'h0, "scr_rd");
      check("scr_rd_const", cmd_data_o, 32'hA5A5_5A5A);
      step(Rd, 8'h10, 32'h0, "stat_wr");
      check("stat_wr_const", cmd_data_o, 32'h1);
      step(Rd, 8'h14, 32'h0, "stat_rd");
      check("stat_rd_const", cmd_data_o, 32'h2);

      // Error sources
      do_reset(1);
      step(Ill, 8'h00, 32'h0, "err_ill");
      step(Wr, 8'h1C, 32'h1234, "err_wr_ro");
      step(Rd, 8'h03, 32'h0, "err_rd_unmapped");
      check("err_unmapped_const", cmd_data_o, 32'h0);
      step(Rd, 8'h18, 32'h0, "err_stat");
      check("err_stat_const", cmd_data_o, 32'h3);
      step(Rd, 8'h1C, 32'h0, "err_id");
      check("err_id_const", cmd_data_o, 32'hC7A1_0001);

      // Reset in the middle of activity
      do_reset(1);
      step(Wr, 8'h04, 32'h15, "mid_wr");
      step(Rd, 8'h04, 32'h0, "mid_rd_pre");
      check("mid_rd_pre_const", cmd_data_o, 32'h15);
      do_reset(1);
      step(Rd, 8'h04, 32'h0, "mid_rd_post");
      check("mid_rd_post_const", cmd_data_o, 32'h0);

      // Saturation of the write counter
      do_reset(1);
      for (int i = 0; i < 65540; i++) step(Wr, 8'h08, 32'(i), "");
      step(Rd, 8'h10, 32'h0, "sat_stat_wr");
      check("sat_const", cmd_data_o, 32'h0000_FFFF);
      step(Rd, 8'h08, 32'h0, "sat_ctrl2");

      // Random commands over mapped, unaligned and arbitrary addresses
      do_reset(1);
      for (int i = 0; i < 800; i++) begin
         c = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            8: a = 8'($urandom);
            9: a = 8'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
            default: a = 8'($urandom_range(0, 7) * 4);
         endcase
         if ($urandom_range(0, 199) == 0) do_reset(1);
         else step(c, a, $urandom, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
